cordic_issue_ctrl: RTL and testbench
====================================

Name: cordic_issue_ctrl

Overview:
Sits between the UART RX message decoder and the pipelined CORDIC core. Buffers incoming theta words and issues them to the CORDIC under credit-based flow control from the TX result buffer. Tags each issued operation with a burst index and last flag, then re-emits the tag aligned with the CORDIC output. Handles flush on RX error or disable and stalls tag tracking whenever the pipeline is stalled.

Parameters:
THETA_W, 48, theta word width in bits
FIFO_DEPTH, 8, theta FIFO entries (power of 2, >=2)
CORDIC_LAT, 16, CORDIC latency in enabled cycles from start to result
CREDITS, 4, result-buffer slots downstream (1..15)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_burst_load  in  1  pulse: load expected operation count
i_burst_len  in  8  operation count; single transaction = 1
i_theta_valid  in  1  theta word valid (no backpressure)
i_theta  in  THETA_W  theta word
i_flush  in  1  abort: RX error or disable command
i_pipeline_en  in  1  CORDIC pipeline enable (stall when 0)
i_credit_ret  in  1  pulse: downstream freed one result slot
o_cordic_start  out  1  issue strobe to CORDIC
o_cordic_theta  out  THETA_W  theta for issued operation
o_res_valid  out  1  CORDIC output valid this cycle (tag aligned)
o_res_idx  out  8  burst index of emerging result
o_res_last  out  1  emerging result is last of burst
o_busy  out  1  state != IDLE
o_ovf_err  out  1  pulse: theta dropped, FIFO full
o_seq_err  out  1  pulse: sequencing violation

Behaviour:
- Reset: all outputs 0; FIFO empty; credits=CREDITS; remaining=0; idx=0; tag pipeline cleared; state IDLE.
- FIFO: write on i_theta_valid when not full. Write while full drops the word and pulses o_ovf_err next cycle. Write while full and popping same cycle is accepted.
- Issue condition: FIFO non-empty && credits>0 && i_pipeline_en && !i_flush && state!=FLUSH. On issue:
  - pop the FIFO;
  - register o_cordic_start=1 and o_cordic_theta;
  - decrement credits, tag {valid, idx, last=(remaining==1)};
  - increment idx and decrement remaining.
- o_cordic_theta holds 0 when not issuing.
- Latency: theta written at edge t gives o_cordic_start high in cycle t+2 at the earliest.
- Credits: issue and return in the same cycle leave credits unchanged. Return at credits==CREDITS saturates and pulses o_seq_err.
- Tag pipeline: CORDIC_LAT-stage shift register. It advances only when i_pipeline_en=1. The issued tag enters on the cycle o_cordic_start is high. Outputs o_res_* are driven from the final stage and valid for one enabled cycle.
- Burst load:
  - i_burst_load sets remaining=i_burst_len and idx=0.
  - i_burst_len==0 is ignored and pulses o_seq_err.
  - Load while remaining!=0 overwrites remaining and pulses o_seq_err.
- Issue with remaining==0: still issued, with last=1; remaining stays 0; o_seq_err pulses.
- FSM:
  - IDLE -> ISSUE on i_burst_load (valid length).
  - ISSUE -> DRAIN when the last operation issues.
  - DRAIN -> IDLE when the tag pipeline is empty and the FIFO is empty.
  - any -> FLUSH on i_flush; FLUSH -> IDLE after 1 cycle.
- Flush (highest priority, also beats a same-cycle i_theta_valid, which is dropped silently):
  - clear FIFO, tag pipeline, remaining and idx;
  - credits=CREDITS;
  - suppress o_cordic_start and o_res_valid from the flush cycle onward;
  - o_busy stays high during FLUSH.
- Stall: with i_pipeline_en=0, no issue and the tag pipeline is frozen; FIFO writes and credit returns still apply.

Decomposition:
- Package cordic_ctrl_pkg: ctrl_state_t enum {IDLE, ISSUE, DRAIN, FLUSH}; tag_t struct {valid, idx[7:0], last}; default localparams.
- One sub-module: sync_fifo, parameterised by width and depth, with full/empty flags, simultaneous push/pop support and a synchronous clear input driven by flush.

Test Plan:
- Single: burst_len=1, theta 48'h0000_1234_5678 -> o_cordic_start 2 cycles after write with same theta; o_res_valid exactly CORDIC_LAT cycles later; idx=0, last=1; o_busy back to 0.
- Burst of 6 thetas, CREDITS=4, no credit return -> exactly 4 issues, then stall. Each i_credit_ret releases one more. Results show idx 0..5; last=1 only on idx 5.
- Stall: toggle i_pipeline_en low for 3 cycles mid-burst -> no issue during the stall; every o_res_valid delayed by exactly 3 cycles; no tag lost or duplicated.
- Overflow: 10 back-to-back theta writes with credits=0, FIFO_DEPTH=8 -> two o_ovf_err pulses; after credits return, 8 issues with idx 0..7.
- Flush mid-burst (3 of 5 issued, 2 in flight) -> no further o_res_valid or o_cordic_start; credits=4; state IDLE after 1 cycle. A new single-theta burst afterwards completes normally with idx=0.
- Sequencing errors -> each of the following gives one o_seq_err pulse with state unchanged:
  - i_burst_len=0;
  - credit return at credits==CREDITS;
  - burst load while a burst is active.

Source files
------------

// File: rtl/cordic_ctrl_pkg.sv
// Shared types and default sizing for the CORDIC issue controller.
// The controller FSM states and the per-operation tag that travels alongside the CORDIC pipeline.
package cordic_ctrl_pkg;

    localparam int DEF_THETA_W    = 48;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_CORDIC_LAT = 16;
    localparam int DEF_CREDITS    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] idx;
        logic       last;
    } tag_t;

endpackage : cordic_ctrl_pkg

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through read port and a synchronous clear.
// A push is accepted while the FIFO is full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty && !i_clr;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_clr;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule : sync_fifo

// File: rtl/cordic_issue_ctrl.sv
// Buffers theta words, issues them to the CORDIC under downstream credit control, and
// shadows the CORDIC pipeline with a tag shift register so each result leaves with its burst index.
module cordic_issue_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int THETA_W    = DEF_THETA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CORDIC_LAT = DEF_CORDIC_LAT,
    parameter int CREDITS    = DEF_CREDITS
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_burst_load,
    input  logic [7:0]         i_burst_len,
    input  logic               i_theta_valid,
    input  logic [THETA_W-1:0] i_theta,
    input  logic               i_flush,
    input  logic               i_pipeline_en,
    input  logic               i_credit_ret,
    output logic               o_cordic_start,
    output logic [THETA_W-1:0] o_cordic_theta,
    output logic               o_res_valid,
    output logic [7:0]         o_res_idx,
    output logic               o_res_last,
    output logic               o_busy,
    output logic               o_ovf_err,
    output logic               o_seq_err
);

    localparam logic [3:0] CREDITS_MAX = 4'(CREDITS);

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_nxt;
    logic [3:0]         r_credits;
    logic [7:0]         r_remaining;
    logic [7:0]         r_idx;
    tag_t               r_start_tag;
    logic [THETA_W-1:0] r_theta;
    tag_t               r_tag_pipe [CORDIC_LAT];
    logic               r_ovf_err;
    logic               r_seq_err;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [THETA_W-1:0] w_fifo_data;
    logic               w_push;
    logic               w_issue;
    logic               w_drop;
    logic               w_load_ok;
    logic               w_seq_err;
    logic               w_pipe_busy;
    tag_t               w_new_tag;
    tag_t               w_res_tag;
    logic               w_res_valid;

    // Flush beats a same-cycle theta write; that word is discarded without an overflow report.
    assign w_push    = i_theta_valid && !i_flush;
    assign w_issue   = !w_fifo_empty && (r_credits != 4'd0) && i_pipeline_en &&
                       !i_flush && (r_state != FLUSH);
    assign w_drop    = w_push && w_fifo_full && !w_issue;
    assign w_load_ok = i_burst_load && (i_burst_len != 8'd0) && !i_flush;

    sync_fifo #(
        .WIDTH (THETA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_theta_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (i_flush),
        .i_push  (w_push),
        .i_pop   (w_issue),
        .i_data  (i_theta),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_new_tag       = '0;
        w_new_tag.valid = 1'b1;
        w_new_tag.idx   = r_idx;
        w_new_tag.last  = (r_remaining <= 8'd1);
    end

    assign w_seq_err = !i_flush && (
                           (i_burst_load && (i_burst_len == 8'd0)) ||
                           (w_load_ok && (r_remaining != 8'd0)) ||
                           (i_credit_ret && !w_issue && (r_credits == CREDITS_MAX)) ||
                           (w_issue && (r_remaining == 8'd0)));

    // The issue register holds through a stall so the CORDIC accepts the operation on the next enabled cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start_tag <= '0;
            r_theta     <= '0;
        end else if (i_flush) begin
            r_start_tag <= '0;
            r_theta     <= '0;
        end else if (i_pipeline_en) begin
            r_start_tag <= w_issue ? w_new_tag : '0;
            r_theta     <= w_issue ? w_fifo_data : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < CORDIC_LAT; k++) r_tag_pipe[k] <= '0;
        end else if (i_flush) begin
            for (int k = 0; k < CORDIC_LAT; k++) r_tag_pipe[k] <= '0;
        end else if (i_pipeline_en) begin
            r_tag_pipe[0] <= r_start_tag;
            for (int k = 1; k < CORDIC_LAT; k++) r_tag_pipe[k] <= r_tag_pipe[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_credits <= CREDITS_MAX;
        end else if (i_flush) begin
            r_credits <= CREDITS_MAX;
        end else if (w_issue && !i_credit_ret) begin
            r_credits <= r_credits - 4'd1;
        end else if (!w_issue && i_credit_ret && (r_credits != CREDITS_MAX)) begin
            r_credits <= r_credits + 4'd1;
        end
    end

    // A burst load takes priority over the index/remaining update of a same-cycle issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= '0;
            r_idx       <= '0;
        end else if (i_flush) begin
            r_remaining <= '0;
            r_idx       <= '0;
        end else if (w_load_ok) begin
            r_remaining <= i_burst_len;
            r_idx       <= '0;
        end else if (w_issue) begin
            r_idx <= r_idx + 8'd1;
            if (r_remaining != 8'd0) r_remaining <= r_remaining - 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_err <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_ovf_err <= w_drop;
            r_seq_err <= w_seq_err;
        end
    end

    always_comb begin
        w_pipe_busy = r_start_tag.valid;
        for (int k = 0; k < CORDIC_LAT; k++) w_pipe_busy = w_pipe_busy | r_tag_pipe[k].valid;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = FLUSH;
        end else begin
            case (r_state)
                IDLE:    if (w_load_ok) w_state_nxt = ISSUE;
                ISSUE:   if (w_issue && (r_remaining == 8'd1) && !w_load_ok) w_state_nxt = DRAIN;
                DRAIN: begin
                    if (w_load_ok)                        w_state_nxt = ISSUE;
                    else if (!w_pipe_busy && w_fifo_empty) w_state_nxt = IDLE;
                end
                FLUSH:   w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // The final stage only counts as a result on an enabled cycle, so a stalled tag is reported once.
    assign w_res_tag   = r_tag_pipe[CORDIC_LAT-1];
    assign w_res_valid = w_res_tag.valid && i_pipeline_en && !i_flush && (r_state != FLUSH);

    assign o_cordic_start = r_start_tag.valid && !i_flush;
    assign o_cordic_theta = i_flush ? '0 : r_theta;
    assign o_res_valid    = w_res_valid;
    assign o_res_idx      = w_res_valid ? w_res_tag.idx : 8'd0;
    assign o_res_last     = w_res_valid && w_res_tag.last;
    assign o_busy         = (r_state != IDLE);
    assign o_ovf_err      = r_ovf_err;
    assign o_seq_err      = r_seq_err;

endmodule : cordic_issue_ctrl

// File: tb/tb_cordic_issue_ctrl.sv
// Directed bench for cordic_issue_ctrl: single op, credit-limited burst, stall, overflow,
// flush and sequencing errors, with expected values worked out by hand.
module tb_cordic_issue_ctrl;

    localparam int THETA_W = 48;
    localparam int LAT     = 16;

    logic               clk;
    logic               rst_n;
    logic               i_burst_load;
    logic [7:0]         i_burst_len;
    logic               i_theta_valid;
    logic [THETA_W-1:0] i_theta;
    logic               i_flush;
    logic               i_pipeline_en;
    logic               i_credit_ret;
    logic               o_cordic_start;
    logic [THETA_W-1:0] o_cordic_theta;
    logic               o_res_valid;
    logic [7:0]         o_res_idx;
    logic               o_res_last;
    logic               o_busy;
    logic               o_ovf_err;
    logic               o_seq_err;

    cordic_issue_ctrl dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_burst_load   (i_burst_load),
        .i_burst_len    (i_burst_len),
        .i_theta_valid  (i_theta_valid),
        .i_theta        (i_theta),
        .i_flush        (i_flush),
        .i_pipeline_en  (i_pipeline_en),
        .i_credit_ret   (i_credit_ret),
        .o_cordic_start (o_cordic_start),
        .o_cordic_theta (o_cordic_theta),
        .o_res_valid    (o_res_valid),
        .o_res_idx      (o_res_idx),
        .o_res_last     (o_res_last),
        .o_busy         (o_busy),
        .o_ovf_err      (o_ovf_err),
        .o_seq_err      (o_seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Event log filled on the falling edge; the main sequence only reads it.
    logic [THETA_W-1:0] iss_theta [$];
    int iss_cyc [$];
    int iss_en  [$];
    int res_idx [$];
    int res_last[$];
    int res_cyc [$];
    int res_en  [$];
    int ovf_cnt = 0;
    int seq_cnt = 0;
    int cyc     = 0;
    int en_cyc  = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_cordic_start && i_pipeline_en) begin
                iss_theta.push_back(o_cordic_theta);
                iss_cyc.push_back(cyc);
                iss_en.push_back(en_cyc);
            end
            if (o_res_valid) begin
                res_idx.push_back(int'(o_res_idx));
                res_last.push_back(int'(o_res_last));
                res_cyc.push_back(cyc);
                res_en.push_back(en_cyc);
            end
            if (o_ovf_err) ovf_cnt++;
            if (o_seq_err) seq_cnt++;
            cyc++;
            if (i_pipeline_en) en_cyc++;
        end
    end

    int b_iss, b_res, b_ovf, b_seq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_iss = iss_theta.size();
        b_res = res_idx.size();
        b_ovf = ovf_cnt;
        b_seq = seq_cnt;
    endtask

    function automatic int n_iss();
        return iss_theta.size() - b_iss;
    endfunction

    function automatic int n_res();
        return res_idx.size() - b_res;
    endfunction

    task automatic burst_load(input int len);
        i_burst_load = 1'b1;
        i_burst_len  = 8'(len);
        tick();
        i_burst_load = 1'b0;
        i_burst_len  = 8'd0;
    endtask

    task automatic write_thetas(input int n, input logic [THETA_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            i_theta_valid = 1'b1;
            i_theta       = base + THETA_W'(i);
            tick();
        end
        i_theta_valid = 1'b0;
        i_theta       = '0;
    endtask

    task automatic credit_ret(input int n);
        for (int i = 0; i < n; i++) begin
            i_credit_ret = 1'b1;
            tick();
        end
        i_credit_ret = 1'b0;
    endtask

    task automatic wait_issues(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && n_iss() < n; i++) tick();
        check(tag, 64'(n_iss()), 64'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && o_busy; i++) tick();
        check(tag, 64'(o_busy), 64'd0);
    endtask

    // Results i = 0..n-1 of the current window: index i, last only on the final one,
    // exactly LAT enabled cycles after the matching issue, which carried theta base+i.
    task automatic check_burst(input string tag, input int n, input logic [THETA_W-1:0] base);
        check({tag, "_nres"}, 64'(n_res()), 64'(n));
        check({tag, "_niss"}, 64'(n_iss()), 64'(n));
        for (int i = 0; i < n && i < n_res() && i < n_iss(); i++) begin
            check($sformatf("%s_theta%0d", tag, i), 64'(iss_theta[b_iss+i]), 64'(base + THETA_W'(i)));
            check($sformatf("%s_idx%0d", tag, i), 64'(res_idx[b_res+i]), 64'(i));
            check($sformatf("%s_last%0d", tag, i), 64'(res_last[b_res+i]), 64'(i == n - 1));
            check($sformatf("%s_lat%0d", tag, i), 64'(res_en[b_res+i] - iss_en[b_iss+i]), 64'(LAT));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        i_burst_load  = 1'b0;
        i_burst_len   = 8'd0;
        i_theta_valid = 1'b0;
        i_theta       = '0;
        i_flush       = 1'b0;
        i_pipeline_en = 1'b1;
        i_credit_ret  = 1'b0;
        tick(3);

        // Reset state
        check("rst_start", 64'(o_cordic_start), 64'd0);
        check("rst_theta", 64'(o_cordic_theta), 64'd0);
        check("rst_res_valid", 64'(o_res_valid), 64'd0);
        check("rst_res_idx", 64'(o_res_idx), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_errs", 64'({o_ovf_err, o_seq_err, o_res_last}), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Single operation: start two cycles after the write, result LAT cycles after start
        snap();
        burst_load(1);
        check("t1_busy", 64'(o_busy), 64'd1);
        i_theta_valid = 1'b1;
        i_theta       = 48'h0000_1234_5678;
        tick();
        i_theta_valid = 1'b0;
        i_theta       = '0;
        check("t1_start_early", 64'(o_cordic_start), 64'd0);
        tick();
        check("t1_start", 64'(o_cordic_start), 64'd1);
        check("t1_theta", 64'(o_cordic_theta), 64'h0000_1234_5678);
        tick();
        check("t1_start_pulse", 64'(o_cordic_start), 64'd0);
        check("t1_theta_zero", 64'(o_cordic_theta), 64'd0);
        wait_idle(60, "t1_idle");
        check_burst("t1", 1, 48'h0000_1234_5678);
        if (n_res() > 0 && n_iss() > 0)
            check("t1_wall_lat", 64'(res_cyc[b_res] - iss_cyc[b_iss]), 64'(LAT));
        credit_ret(1);
        tick(2);
        check("t1_seq", 64'(seq_cnt - b_seq), 64'd0);

        // Burst of 6 with 4 credits: 4 issue, then one per returned credit
        snap();
        burst_load(6);
        write_thetas(6, 48'h0000_0000_0100);
        tick(10);
        check("t2_issue4", 64'(n_iss()), 64'd4);
        credit_ret(1);
        tick(4);
        check("t2_issue5", 64'(n_iss()), 64'd5);
        credit_ret(1);
        tick(4);
        check("t2_issue6", 64'(n_iss()), 64'd6);
        wait_idle(60, "t2_idle");
        check_burst("t2", 6, 48'h0000_0000_0100);
        credit_ret(4);
        tick(2);
        check("t2_seq", 64'(seq_cnt - b_seq), 64'd0);

        // Stall for 3 cycles mid-burst: nothing accepted, results shifted by 3
        snap();
        burst_load(4);
        write_thetas(4, 48'h0000_0000_0200);
        i_pipeline_en = 1'b0;
        check("t3_pre_stall", 64'(n_iss()), 64'd2);
        tick(3);
        check("t3_during_stall", 64'(n_iss()), 64'd2);
        i_pipeline_en = 1'b1;
        wait_idle(80, "t3_idle");
        check_burst("t3", 4, 48'h0000_0000_0200);
        if (n_res() > 0 && n_iss() > 0)
            check("t3_wall_lat0", 64'(res_cyc[b_res] - iss_cyc[b_iss]), 64'(LAT + 3));

        // Overflow with no credits: 10 writes into 8 entries drop two
        snap();
        burst_load(8);
        write_thetas(10, 48'h0000_0000_0300);
        tick(3);
        check("t4_ovf", 64'(ovf_cnt - b_ovf), 64'd2);
        check("t4_no_issue", 64'(n_iss()), 64'd0);
        credit_ret(4);
        wait_issues(4, 20, "t4_issue4");
        credit_ret(4);
        wait_issues(8, 20, "t4_issue8");
        wait_idle(60, "t4_idle");
        check_burst("t4", 8, 48'h0000_0000_0300);
        credit_ret(4);
        tick(2);
        check("t4_seq", 64'(seq_cnt - b_seq), 64'd0);

        // Flush with 3 issued and 2 still queued
        snap();
        burst_load(5);
        write_thetas(3, 48'h0000_0000_0400);
        wait_issues(3, 10, "t5_issue3");
        i_pipeline_en = 1'b0;
        write_thetas(2, 48'h0000_0000_0403);
        i_flush = 1'b1;
        tick();
        i_flush       = 1'b0;
        i_pipeline_en = 1'b1;
        check("t5_busy_flush", 64'(o_busy), 64'd1);
        tick();
        check("t5_idle_after", 64'(o_busy), 64'd0);
        tick(30);
        check("t5_no_more_issue", 64'(n_iss()), 64'd3);
        check("t5_no_result", 64'(n_res()), 64'd0);
        snap();
        burst_load(1);
        write_thetas(1, 48'h0000_0000_0500);
        wait_idle(60, "t5_single_idle");
        check_burst("t5s", 1, 48'h0000_0000_0500);
        // Three more issue without any returns only if the flush refilled all credits
        snap();
        burst_load(3);
        write_thetas(3, 48'h0000_0000_0600);
        wait_idle(60, "t5_refill_idle");
        check_burst("t5r", 3, 48'h0000_0000_0600);
        credit_ret(4);
        tick(2);
        check("t5_seq", 64'(seq_cnt - b_seq), 64'd0);

        // Sequencing errors: one pulse each, state unchanged
        snap();
        burst_load(0);
        tick(2);
        check("t6_len0_seq", 64'(seq_cnt - b_seq), 64'd1);
        check("t6_len0_busy", 64'(o_busy), 64'd0);
        snap();
        credit_ret(1);
        tick(2);
        check("t6_credit_seq", 64'(seq_cnt - b_seq), 64'd1);
        check("t6_credit_busy", 64'(o_busy), 64'd0);
        burst_load(3);
        check("t6_active", 64'(o_busy), 64'd1);
        snap();
        burst_load(2);
        tick(2);
        check("t6_reload_seq", 64'(seq_cnt - b_seq), 64'd1);
        check("t6_reload_busy", 64'(o_busy), 64'd1);
        snap();
        write_thetas(2, 48'h0000_0000_0700);
        wait_idle(60, "t6_idle");
        check_burst("t6", 2, 48'h0000_0000_0700);
        credit_ret(2);
        tick(2);
        check("t6_seq_clean", 64'(seq_cnt - b_seq), 64'd0);
        check("t6_ovf_clean", 64'(ovf_cnt - b_ovf), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cordic_issue_ctrl
